bin_to_bcd_serial: RTL and testbench
====================================

# bin_to_bcd_serial

Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It produces the packed BCD operands consumed by the team's two-digit BCD adder/subtractor and BCD display paths, converting a binary count or result into decimal digits. Input and output each use a valid/ready handshake, and one conversion is in flight at a time.

## Interface
- `W`, default 8: binary input width, ≥1.
- `D`, default 3: BCD output digits. Must satisfy 10^D > 2^W − 1. Any other value is an illegal configuration and fails at elaboration.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `in_valid` input, 1 bit: `in_bin` holds a value to convert.
- `in_ready` output, 1 bit: the converter accepts a new value this cycle.
- `in_bin` input, W bits: unsigned binary operand.
- `out_valid` output, 1 bit: `out_bcd` holds a finished result.
- `out_ready` input, 1 bit: the consumer takes the result this cycle.
- `out_bcd` output, 4·D bits: packed BCD, digit 0 (units) in bits [3:0], digit k in bits [4k+3:4k].

## Operation
- State machine states: IDLE, SHIFT, HOLD.
  - IDLE: `in_ready`=1. If `in_valid` is high at a rising edge, the block loads `in_bin` into the binary shift register, clears the BCD register, sets the bit counter to W, and moves to SHIFT.
  - SHIFT, one step per cycle:
    - Every digit ≥5 gets +3. The correction is computed on each digit in parallel from the pre-step value.
    - The whole {BCD, binary} register then shifts left by 1. The binary MSB enters BCD bit 0.
    - The counter decrements. On the step where the counter reaches 0, the next state is HOLD.
  - HOLD: `out_valid`=1 and `out_bcd` is stable. When `out_valid` and `out_ready` are both high at a rising edge, the next state is IDLE.
- `in_ready` is high only in IDLE, and `out_valid` is high only in HOLD. There is no same-cycle pass-through from HOLD to acceptance.
- `in_bin` is sampled only at the accepting edge. Changes to it afterwards have no effect.
- In SHIFT and HOLD, `in_valid` is ignored and no input is lost, because `in_ready`=0.
- Every BCD digit of `out_bcd` lies in 0..9. Unused upper digits are 0.
- `out_bcd` is registered and holds its value from entry to HOLD until the next conversion begins clearing it. It is don't-care while `out_valid`=0.
- Reset (asynchronous, any state, including mid-SHIFT):
  - state goes to IDLE and the counter to 0;
  - the BCD and binary registers go to 0;
  - `in_ready`=1, `out_valid`=0, `out_bcd`=0.
  - The partial conversion is discarded and nothing is emitted.

## Timing
- Acceptance at edge t0, SHIFT steps at edges t0+1 … t0+W, `out_valid` high after edge t0+W. Latency is W cycles from accepting edge to valid output, which is 8 for the defaults.
- The earliest next acceptance is edge t1+1, where t1 is the output handshake edge. Throughput is at best one conversion per W+2 cycles.
- Back-pressure: HOLD persists indefinitely while `out_ready`=0. `out_ready` high outside HOLD has no effect.
- `in_ready` and `out_valid` are pure decodes of the state register, with no combinational path from `in_valid` or `out_ready`.
- Reset assertion takes effect immediately, without waiting for a clock edge. After deassertion, the first accepting edge is the first rising edge.

## Test plan
- Reset, then `in_bin`=0 accepted → `out_valid` exactly 8 cycles later, `out_bcd`=0x000. Hold `out_ready`=1 → back to IDLE, `in_ready`=1 one cycle after the handshake.
- `in_bin`=255 → `out_bcd`=0x255. `in_bin`=99 → 0x099. `in_bin`=100 → 0x100. `in_bin`=9 → 0x009.
- Back-pressure: convert 173 with `out_ready`=0 for 20 cycles → `out_bcd`=0x173 stable and `out_valid`=1 throughout. Toggle `in_valid` and `in_bin` during this time → no effect. Raise `out_ready` → one handshake only.
- Back-to-back: keep `in_valid`=1 and `out_ready`=1 with values 1, 2, … 255 → every result matches its decimal value, and accepting edges are spaced exactly W+2 cycles apart.
- Async reset at SHIFT step 4 of a conversion of 200, asserted between clock edges → outputs take reset values immediately and no `out_valid` pulse appears. A subsequent conversion of 37 yields 0x037.
- Parameter sweep W=4/D=2 (exhaustive 0..15) and W=10/D=4 (exhaustive 0..1023) → results match the reference model, and latency equals W.

Source files
------------

// File: rtl/bin_to_bcd_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_serial_if
// Description : Valid/ready handshake bundle between a binary producer, the
//               serial binary-to-BCD converter and the BCD consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_serial_if #(
    parameter int W = 8,
    parameter int D = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_bin;
    logic             out_valid;
    logic             out_ready;
    logic [4*D-1:0]   out_bcd;

    // Converter side
    modport slave (
        input  in_valid,
        input  in_bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bcd
    );

    // Producer / consumer side
    modport master (
        output in_valid,
        output in_bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bcd
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_serial.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_serial
// Description : Sequential shift-and-add-3 binary-to-packed-BCD converter,
//               one bit per clock, valid/ready on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_serial #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    bin_to_bcd_serial_if.slave    bus
);
    localparam int c_cnt_w = $clog2(W + 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_hold  = 2'd2;

    // Legal only when D digits can hold the largest W-bit value.
    function automatic bit cfg_ok();
        logic [319:0] p;
        logic [319:0] m;
        p = 320'd1;
        for (int i = 0; i < D; i++) p = p * 320'd10;
        m = (320'd1 << W) - 320'd1;
        return (W >= 1) && (D >= 1) && (p > m);
    endfunction

    generate
        if (!cfg_ok()) begin : g_cfg_check
            $fatal(1, "bin_to_bcd_serial: D digits cannot represent 2^W-1");
        end
    endgenerate

    logic [1:0]         state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q,   cnt_d;
    logic [4*D-1:0]     bcd_q,   bcd_d;
    logic [W-1:0]       bin_q,   bin_d;
    logic [4*D-1:0]     w_bcd_adj;

    // Add-3 correction, every digit from its pre-shift value.
    generate
        for (genvar k = 0; k < D; k++) begin : g_digit
            assign w_bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5)
                                       ? bcd_q[4*k +: 4] + 4'd3
                                       : bcd_q[4*k +: 4];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        case (state_q)
            c_idle: begin
                if (bus.in_valid) begin
                    bin_d   = bus.in_bin;
                    bcd_d   = '0;
                    cnt_d   = c_cnt_w'(W);
                    state_d = c_shift;
                end
            end
            c_shift: begin
                {bcd_d, bin_d} = {w_bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q - c_cnt_w'(1);
                if (cnt_q == c_cnt_w'(1)) state_d = c_hold;
            end
            c_hold: begin
                if (bus.out_ready) state_d = c_idle;
            end
            default: state_d = c_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_idle;
            cnt_q   <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
        end
    end

    assign bus.in_ready  = (state_q == c_idle);
    assign bus.out_valid = (state_q == c_hold);
    assign bus.out_bcd   = bcd_q;
endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_serial
// Description : Directed self-checking bench for bin_to_bcd_serial at
//               W=8/D=3, W=4/D=2 and W=10/D=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_serial_if #(.W(8),  .D(3)) b8  ();
    bin_to_bcd_serial_if #(.W(4),  .D(2)) b4  ();
    bin_to_bcd_serial_if #(.W(10), .D(4)) b10 ();

    bin_to_bcd_serial #(.W(8),  .D(3)) dut8  (.clk(clk), .rst(rst), .bus(b8));
    bin_to_bcd_serial #(.W(4),  .D(2)) dut4  (.clk(clk), .rst(rst), .bus(b4));
    bin_to_bcd_serial #(.W(10), .D(4)) dut10 (.clk(clk), .rst(rst), .bus(b10));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal digits by division, independent of the shift-and-add method.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic conv8(input int v, output logic [11:0] bcd, output int lat);
        int n;
        n = 0;
        while (!b8.in_ready && n < 50) begin tick(); n++; end
        if (!b8.in_ready) begin lat = -1; bcd = 'x; return; end
        b8.in_bin = 8'(v); b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        lat = 0;
        while (!b8.out_valid && lat < 50) begin tick(); lat++; end
        bcd = b8.out_bcd;
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;
    endtask

    task automatic conv4(input int v, output logic [7:0] bcd, output int lat);
        int n;
        n = 0;
        while (!b4.in_ready && n < 50) begin tick(); n++; end
        if (!b4.in_ready) begin lat = -1; bcd = 'x; return; end
        b4.in_bin = 4'(v); b4.in_valid = 1'b1;
        tick();
        b4.in_valid = 1'b0;
        lat = 0;
        while (!b4.out_valid && lat < 50) begin tick(); lat++; end
        bcd = b4.out_bcd;
        b4.out_ready = 1'b1;
        tick();
        b4.out_ready = 1'b0;
    endtask

    task automatic conv10(input int v, output logic [15:0] bcd, output int lat);
        int n;
        n = 0;
        while (!b10.in_ready && n < 50) begin tick(); n++; end
        if (!b10.in_ready) begin lat = -1; bcd = 'x; return; end
        b10.in_bin = 10'(v); b10.in_valid = 1'b1;
        tick();
        b10.in_valid = 1'b0;
        lat = 0;
        while (!b10.out_valid && lat < 50) begin tick(); lat++; end
        bcd = b10.out_bcd;
        b10.out_ready = 1'b1;
        tick();
        b10.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({b8.in_ready, b8.out_valid, b8.out_bcd} !== {1'b1, 1'b0, 12'h000}) begin
            n_bad++;
            $display("FAIL reset8: rdy/vld/bcd=%b/%b/%h want 1/0/000", b8.in_ready, b8.out_valid, b8.out_bcd);
        end
        n_cmp++;
        if ({b4.in_ready, b4.out_valid, b4.out_bcd, b10.in_ready, b10.out_valid, b10.out_bcd}
            !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset4_10: b4 %b/%b/%h b10 %b/%b/%h want 1/0/00 1/0/0000",
                     b4.in_ready, b4.out_valid, b4.out_bcd, b10.in_ready, b10.out_valid, b10.out_bcd);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int vals [5] = '{0, 255, 99, 100, 9};
        logic [11:0] bcd;
        int lat;
        for (int i = 0; i < 5; i++) begin
            conv8(vals[i], bcd, lat);
            n_cmp++;
            if (bcd !== ref_bcd(vals[i])[11:0]) begin
                n_bad++;
                $display("FAIL basic_bcd(%0d): got %h want %h", vals[i], bcd, ref_bcd(vals[i])[11:0]);
            end
            n_cmp++;
            if (lat !== 8) begin
                n_bad++;
                $display("FAIL basic_latency(%0d): got %0d want 8", vals[i], lat);
            end
            n_cmp++;
            if ({b8.in_ready, b8.out_valid} !== 2'b10) begin
                n_bad++;
                $display("FAIL basic_idle_after_hs(%0d): rdy/vld=%b/%b want 1/0", vals[i], b8.in_ready, b8.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        b8.in_bin = 8'd173; b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        lat = 0;
        while (!b8.out_valid && lat < 50) begin tick(); lat++; end
        n_cmp++;
        if (lat !== 8) begin
            n_bad++;
            $display("FAIL bp_latency: got %0d want 8", lat);
        end
        for (int i = 0; i < 20; i++) begin
            b8.in_valid = 1'($urandom_range(0, 1));
            b8.in_bin   = 8'($urandom);
            tick();
            n_cmp++;
            if ({b8.out_valid, b8.in_ready, b8.out_bcd} !== {1'b1, 1'b0, 12'h173}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: vld/rdy/bcd=%b/%b/%h want 1/0/173", i, b8.out_valid, b8.in_ready, b8.out_bcd);
            end
        end
        b8.in_valid = 1'b0;
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;
        n_cmp++;
        if ({b8.out_valid, b8.in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_release: vld/rdy=%b/%b want 0/1", b8.out_valid, b8.in_ready);
        end
        tick(); tick();
        n_cmp++;
        if ({b8.out_valid, b8.in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_single_hs: vld/rdy=%b/%b want 0/1", b8.out_valid, b8.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int prev, t_acc, n, lat;
        prev = -1;
        b8.out_ready = 1'b1;
        b8.in_valid  = 1'b1;
        for (int v = 1; v <= 255; v++) begin
            b8.in_bin = 8'(v);
            n = 0;
            while (!b8.in_ready && n < 50) begin tick(); n++; end
            t_acc = cyc;
            tick();
            if (prev >= 0) begin
                n_cmp++;
                if (t_acc - prev !== 10) begin
                    n_bad++;
                    $display("FAIL b2b_spacing(%0d): got %0d want 10", v, t_acc - prev);
                end
            end
            prev = t_acc;
            lat = 0;
            while (!b8.out_valid && lat < 50) begin tick(); lat++; end
            n_cmp++;
            if (b8.out_bcd !== ref_bcd(v)[11:0]) begin
                n_bad++;
                $display("FAIL b2b_bcd(%0d): got %h want %h", v, b8.out_bcd, ref_bcd(v)[11:0]);
            end
        end
        b8.in_valid = 1'b0;
        tick();
        b8.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [11:0] bcd;
        int lat;
        int pulses;
        b8.in_bin = 8'd200; b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({b8.in_ready, b8.out_valid, b8.out_bcd} !== {1'b1, 1'b0, 12'h000}) begin
            n_bad++;
            $display("FAIL async_reset: rdy/vld/bcd=%b/%b/%h want 1/0/000", b8.in_ready, b8.out_valid, b8.out_bcd);
        end
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (b8.out_valid) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL async_no_emit: got %0d valid cycles want 0", pulses);
        end
        conv8(37, bcd, lat);
        n_cmp++;
        if ({bcd, 8'(lat)} !== {12'h037, 8'd8}) begin
            n_bad++;
            $display("FAIL async_followup: bcd=%h lat=%0d want 037 lat 8", bcd, lat);
        end
    endtask

    task automatic test_sweep_w4();
        logic [7:0] bcd;
        int lat;
        for (int v = 0; v < 16; v++) begin
            conv4(v, bcd, lat);
            n_cmp++;
            if (bcd !== ref_bcd(v)[7:0] || lat !== 4) begin
                n_bad++;
                $display("FAIL sweep4(%0d): bcd=%h lat=%0d want %h lat 4", v, bcd, lat, ref_bcd(v)[7:0]);
            end
        end
    endtask

    task automatic test_sweep_w10();
        logic [15:0] bcd;
        int lat;
        for (int v = 0; v < 1024; v++) begin
            conv10(v, bcd, lat);
            n_cmp++;
            if (bcd !== ref_bcd(v) || lat !== 10) begin
                n_bad++;
                $display("FAIL sweep10(%0d): bcd=%h lat=%0d want %h lat 10", v, bcd, lat, ref_bcd(v));
            end
        end
    endtask

    initial begin
        b8.in_valid = 1'b0;  b8.in_bin = '0;  b8.out_ready = 1'b0;
        b4.in_valid = 1'b0;  b4.in_bin = '0;  b4.out_ready = 1'b0;
        b10.in_valid = 1'b0; b10.in_bin = '0; b10.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_sweep_w4();
        test_sweep_w10();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
